// File: rtl/regbank_access_ctrl.sv
// ============================================================================
// regbank_access_ctrl : debug/loader initiator for register_bank
//                       (single read/write + full-bank dump over valid/ready)
// Revision 1.0
// ============================================================================
`default_nettype none

module regbank_access_ctrl #(
   parameter int NREGS = 32,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic          req_dump,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [AW-1:0] resp_addr,
   output logic [DW-1:0] resp_data,
   output logic          resp_last,
   output logic [AW-1:0] read_reg_1,
   input  logic [DW-1:0] read_data_1,
   output logic [AW-1:0] write_reg,
   output logic [DW-1:0] write_data,
   output logic          write_enable
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WRITE     = 3'd1;
   localparam logic [2:0] S_READ      = 3'd2;
   localparam logic [2:0] S_RESP      = 3'd3;
   localparam logic [2:0] S_DUMP_RD   = 3'd4;
   localparam logic [2:0] S_DUMP_RESP = 3'd5;

   localparam logic [AW:0]   C_NREGS = (AW+1)'(NREGS);
   localparam logic [AW-1:0] C_LAST  = AW'(NREGS - 1);

   logic [2:0]    r_state;
   logic [AW-1:0] r_cnt;
   logic          r_rd_ok;
   logic          w_in_range;

   assign w_in_range = ({1'b0, req_addr} < C_NREGS);

   // Strobes decode straight from state so an async reset drops them at once.
   assign req_ready    = (r_state == S_IDLE) && !rst;
   assign write_enable = (r_state == S_WRITE);
   assign resp_valid   = (r_state == S_RESP) || (r_state == S_DUMP_RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_rd_ok    <= 1'b0;
         read_reg_1 <= '0;
         write_reg  <= '0;
         write_data <= '0;
         resp_addr  <= '0;
         resp_data  <= '0;
         resp_last  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  write_reg  <= req_addr;
                  write_data <= req_wdata;
                  r_rd_ok    <= w_in_range;
                  if (req_dump) begin
                     r_cnt      <= '0;
                     read_reg_1 <= '0;
                     r_state    <= S_DUMP_RD;
                  end else if (req_write) begin
                     // Out-of-range writes are swallowed without a strobe.
                     r_state <= w_in_range ? S_WRITE : S_IDLE;
                  end else begin
                     read_reg_1 <= req_addr;
                     r_state    <= S_READ;
                  end
               end
            end
            S_WRITE: r_state <= S_IDLE;
            S_READ: begin
               resp_data <= r_rd_ok ? read_data_1 : '0;
               resp_addr <= read_reg_1;
               resp_last <= 1'b1;
               r_state   <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready) r_state <= S_IDLE;
            end
            S_DUMP_RD: begin
               resp_data <= read_data_1;
               resp_addr <= r_cnt;
               resp_last <= (r_cnt == C_LAST);
               r_state   <= S_DUMP_RESP;
            end
            S_DUMP_RESP: begin
               if (resp_ready) begin
                  if (resp_last) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_cnt      <= r_cnt + AW'(1);
                     read_reg_1 <= r_cnt + AW'(1);
                     r_state    <= S_DUMP_RD;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_regbank_access_ctrl.sv
// ============================================================================
// tb_regbank_access_ctrl : directed self-checking bench with a register_bank model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_regbank_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write, req_dump;
   logic [4:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid, resp_ready, resp_last;
   logic [4:0]  resp_addr;
   logic [31:0] resp_data;
   logic [4:0]  read_reg_1, write_reg;
   logic [31:0] read_data_1, write_data;
   logic        write_enable;

   logic [31:0] bank [32];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          we_pulses = 0;

   always #5 clk = ~clk;

   regbank_access_ctrl #(.NREGS(32), .AW(5), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_dump(req_dump), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_addr(resp_addr),
      .resp_data(resp_data), .resp_last(resp_last),
      .read_reg_1(read_reg_1), .read_data_1(read_data_1),
      .write_reg(write_reg), .write_data(write_data), .write_enable(write_enable)
   );

   // register_bank stand-in: combinational read, write on rising edge
   assign read_data_1 = bank[read_reg_1];
   always @(posedge clk) begin
      if (write_enable) begin
         bank[write_reg] <= write_data;
         we_pulses = we_pulses + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_dump = 1'b0; req_addr = a; req_wdata = d;
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = 1'b0;
      chk("we_on", 32'(write_enable), 32'd1);
      chk("wr_reg", 32'(write_reg), 32'(a));
      chk("wr_data", write_data, d);
      @(posedge clk); #1;
      chk("we_off", 32'(write_enable), 32'd0);
   endtask

   task automatic do_read(input logic [4:0] a, input logic [31:0] exp);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_dump = 1'b0; req_addr = a;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rd_pending", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      chk("rd_valid", 32'(resp_valid), 32'd1);
      chk("rd_data", resp_data, exp);
      chk("rd_addr", 32'(resp_addr), 32'(a));
      chk("rd_last", 32'(resp_last), 32'd1);
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("rd_done", 32'(resp_valid), 32'd0);
      chk("rd_ready_back", 32'(req_ready), 32'd1);
   endtask

   task automatic do_dump(input bit stall);
      int n = 0;
      int cyc = 0;
      bit done = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_dump = 1'b1; req_write = 1'b1; req_addr = 5'd9;
      @(posedge clk); #1;
      req_valid = 1'b0; req_dump = 1'b0; req_write = 1'b0;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         resp_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (resp_valid && resp_ready) begin
            chk("dump_addr", 32'(resp_addr), 32'(n));
            chk("dump_data", resp_data, 32'(n * 3));
            chk("dump_last", 32'(resp_last), 32'(n == 31));
            if (resp_last) done = 1'b1;
            n++;
         end
      end
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("dump_count", 32'(n), 32'd32);
      chk("dump_idle", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      logic [31:0] held;
      for (int i = 0; i < 32; i++) bank[i] = '0;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_dump = 1'b0;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_we", 32'(write_enable), 32'd0);
      chk("rst_rd_reg", 32'(read_reg_1), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_last", 32'(resp_last), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("idle_ready", 32'(req_ready), 32'd1);

      // 1: write then read back
      p0 = we_pulses;
      do_write(5'd2, 32'd69);
      chk("we_pulse_count", 32'(we_pulses - p0), 32'd1);
      do_read(5'd2, 32'd69);

      // 2: overwrite and neighbouring register
      do_write(5'd2, 32'd420);
      do_read(5'd2, 32'd420);
      do_write(5'd5, 32'd1234);
      do_read(5'd5, 32'd1234);
      do_read(5'd2, 32'd420);

      // 3: consumer stalls for 5 cycles
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd5;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      held = resp_data;
      chk("stall_first", held, 32'd1234);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("stall_valid", 32'(resp_valid), 32'd1);
         chk("stall_data", resp_data, 32'd1234);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("stall_done", 32'(resp_valid), 32'd0);

      // 4: preload i*3 and dump without stalls
      for (int i = 0; i < 32; i++) do_write(5'(i), 32'(i * 3));
      do_dump(1'b0);

      // 5: dump with random consumer stalls
      do_dump(1'b1);

      // 6: reset in the middle of a write
      p0 = we_pulses;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd7; req_wdata = 32'd55;
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = 1'b0;
      chk("abort_we_on", 32'(write_enable), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort_we_off", 32'(write_enable), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort_no_pulse", 32'(we_pulses - p0), 32'd0);
      do_read(5'd7, 32'd21);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
